scan_mux: RTL and testbench

- Parametrised, registered N-channel, W-bit-wide multiplexer. Generalises the fixed 7-to-1 single-bit switch mux.
- Three modes:
  - Manual select.
  - Timed round-robin auto-scan over a channel-enable mask.
  - Hold (freeze).
- Sits between the switch/sensor inputs and LEDR/HEX display logic in top-level designs; drives a display-update strobe.

---
 rtl/scan_mux_pkg.sv | 28 ++
 rtl/scan_mux_if.sv | 41 ++++
 rtl/scan_mux_next_enabled_finder.sv | 48 ++++
 rtl/scan_mux.sv | 121 ++++++++++++
 tb/tb_scan_mux.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared encodings, state type and helpers for scan_mux
//
// Purpose: mode encodings, the controller state enum and a constant-foldable
//          clog2 used to size select/counter fields.
// Ports:   none (package).
package scan_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// rtl/scan_mux_if.sv - channel/control/display bundle for scan_mux
//
// Purpose: groups the multiplexer data, control and display-side signals.
// Ports (signals):
//   inp       N_CH*W  packed channel data, channel k at inp[k*W +: W]
//   sel       SEL_W   manual channel select
//   mode      2       00 manual, 01 scan, 10 hold, 11 manual
//   en_mask   N_CH    per-channel enable
//   out       W       registered selected data
//   cur_ch    SEL_W   channel currently driving out
//   out_valid 1       out reflects an enabled, in-range channel
//   update    1       one-cycle pulse when cur_ch changes
// Modports: master drives inputs / observes outputs, slave is the mux.
interface scan_mux_if #(
  parameter int N_CH = 7,
  parameter int W    = 1
);
  import scan_mux_pkg::*;

  localparam int SEL_W = clog2(N_CH);

  logic [N_CH*W-1:0] inp;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        mode;
  logic [N_CH-1:0]   en_mask;
  logic [W-1:0]      out;
  logic [SEL_W-1:0]  cur_ch;
  logic              out_valid;
  logic              update;

  modport master (
    output inp, sel, mode, en_mask,
    input  out, cur_ch, out_valid, update
  );

  modport slave (
    input  inp, sel, mode, en_mask,
    output out, cur_ch, out_valid, update
  );

endinterface

// File: rtl/scan_mux_next_enabled_finder.sv
// rtl/scan_mux_next_enabled_finder.sv - circular search for the next enabled channel
//
// Purpose: returns the first set en_mask bit strictly after from_ch, wrapping
//          N_CH-1 -> 0. The search ends on from_ch itself, so a lone enabled
//          channel returns its own index. An out-of-range from_ch searches from 0.
// Ports:
//   en_mask  in   N_CH   channel enables
//   from_ch  in   SEL_W  search origin
//   next_ch  out  SEL_W  next enabled channel (from_ch when none)
//   none     out  1      no channel enabled at all
module scan_mux_next_enabled_finder
  import scan_mux_pkg::*;
#(
  parameter int N_CH = 7
) (
  input  logic [N_CH-1:0]          en_mask,
  input  logic [clog2(N_CH)-1:0]   from_ch,
  output logic [clog2(N_CH)-1:0]   next_ch,
  output logic                     none
);

  localparam int SEL_W = clog2(N_CH);
  localparam int N_PAD = 1 << SEL_W;

  logic [N_PAD-1:0] mask_pad;
  assign mask_pad = N_PAD'(en_mask);

  always_comb begin
    int               start;
    int               c;
    logic             found;
    logic [SEL_W-1:0] ci;
    next_ch = from_ch;
    found   = 1'b0;
    ci      = '0;
    start   = (int'(from_ch) >= N_CH) ? N_CH - 1 : int'(from_ch);
    for (int k = 1; k <= N_CH; k++) begin
      c  = (start + k) % N_CH;
      ci = SEL_W'(c);
      if (!found && mask_pad[ci]) begin
        found   = 1'b1;
        next_ch = ci;
      end
    end
    none = !found;
  end

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N-channel mux with manual, timed auto-scan and hold modes
//
// Purpose: selects one W-bit channel of inp onto out. Manual follows sel, scan
//          rotates over the enabled channels every DWELL cycles, hold freezes.
//          Mode is registered, so behaviour lags the mode input by one cycle.
// Ports:
//   CLOCK_50  in   rising-edge system clock
//   resetn    in   asynchronous active-low reset
//   bus       slave modport of scan_mux_if (inp/sel/mode/en_mask in,
//             out/cur_ch/out_valid/update out)
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 7,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic     CLOCK_50,
  input  logic     resetn,
  scan_mux_if.slave bus
);

  localparam int SEL_W = clog2(N_CH);
  localparam int N_PAD = 1 << SEL_W;
  localparam int CNT_W = clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state, state_next;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_next, scan_next_ch;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             scan_none;
  logic [N_PAD-1:0] mask_pad;
  logic [W-1:0]     sel_data;
  logic             chan_ok;
  logic [W-1:0]     out_q;
  logic             out_valid_q, update_q;

  // Padding to a power of two makes out-of-range indices read as disabled.
  assign mask_pad = N_PAD'(bus.en_mask);

  scan_mux_next_enabled_finder #(.N_CH(N_CH)) u_finder (
    .en_mask (bus.en_mask),
    .from_ch (cur_ch_q),
    .next_ch (scan_next_ch),
    .none    (scan_none)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_MANUAL;
    else         state <= state_next;
  end

  always_comb begin
    case (bus.mode)
      MODE_SCAN: state_next = ST_SCAN;
      MODE_HOLD: state_next = ST_HOLD;
      default:   state_next = ST_MANUAL;
    endcase
  end

  always_comb begin
    cur_ch_next = cur_ch_q;
    cnt_next    = cnt_q;
    case (state)
      ST_MANUAL: begin
        cur_ch_next = bus.sel;
        cnt_next    = '0;
      end
      ST_SCAN: begin
        // A pending mode change suppresses any scan advance on this edge.
        if (state_next == ST_SCAN) begin
          if (scan_none) begin
            cnt_next = '0;
          end else if (!mask_pad[cur_ch_q] || cnt_q == CNT_LAST) begin
            cur_ch_next = scan_next_ch;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    sel_data = '0;
    chan_ok  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_ch_next == SEL_W'(k) && bus.en_mask[k]) begin
        sel_data = bus.inp[k*W +: W];
        chan_ok  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cur_ch_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      update_q    <= 1'b0;
    end else if (state == ST_HOLD) begin
      update_q <= 1'b0;
    end else begin
      cur_ch_q    <= cur_ch_next;
      cnt_q       <= cnt_next;
      out_q       <= sel_data;
      out_valid_q <= chan_ok;
      update_q    <= (cur_ch_next != cur_ch_q);
    end
  end

  assign bus.out       = out_q;
  assign bus.cur_ch    = cur_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.update    = update_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - scoreboard bench for scan_mux against a behavioural model
module tb_scan_mux;
  import scan_mux_pkg::*;

  localparam int N_CH  = 7;
  localparam int W     = 1;
  localparam int DWELL = 4;
  localparam int SEL_W = clog2(N_CH);
  localparam int DW    = N_CH * W;
  localparam int RW    = W + SEL_W + 2;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;

  scan_mux_if #(.N_CH(N_CH), .W(W)) bus ();

  scan_mux #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors    = 0;
  int miscompares = 0;

  logic [RW-1:0] exp_q[$];
  string         tag_q[$];

  // Reference model: what the outputs must read after the coming edge.
  int           m_state;
  int           m_cur;
  int           m_cnt;
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_upd;

  function automatic bit chan_on(input int c, input logic [N_CH-1:0] msk);
    logic [N_CH-1:0] sh;
    sh = msk >> c;
    return (c < N_CH) && sh[0];
  endfunction

  function automatic int next_on(input int from, input logic [N_CH-1:0] msk);
    int idx;
    idx = (from >= N_CH) ? 0 : from + 1;
    for (int n = 0; n < N_CH; n++) begin
      if (chan_on(idx % N_CH, msk)) return idx % N_CH;
      idx++;
    end
    return from;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_cnt = 0;
    m_out = '0; m_valid = 1'b0; m_upd = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] md, input int s,
                            input logic [N_CH-1:0] msk, input logic [DW-1:0] d);
    int nc, ncnt, want;
    logic [DW-1:0] shd;
    bit ok;
    want = (md == 2'b01) ? 1 : (md == 2'b10) ? 2 : 0;
    if (m_state == 2) begin
      m_upd = 1'b0;
    end else begin
      nc = m_cur;
      ncnt = m_cnt;
      if (m_state == 0) begin
        nc = s;
        ncnt = 0;
      end else if (want == 1) begin
        if (msk == '0) ncnt = 0;
        else if (!chan_on(m_cur, msk) || m_cnt == DWELL - 1) begin
          nc = next_on(m_cur, msk);
          ncnt = 0;
        end else ncnt = m_cnt + 1;
      end
      ok = chan_on(nc, msk);
      shd = d >> (nc * W);
      m_out = ok ? shd[W-1:0] : '0;
      m_valid = ok;
      m_upd = (nc != m_cur);
      m_cur = nc;
      m_cnt = ncnt;
    end
    m_state = want;
  endtask

  function automatic logic [RW-1:0] model_vec();
    return {m_out, SEL_W'(m_cur), m_valid, m_upd};
  endfunction

  task automatic compare(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got out=%0h cur_ch=%0d out_valid=%0b update=%0b, expected out=%0h cur_ch=%0d out_valid=%0b update=%0b",
               tag, act[RW-1 -: W], act[SEL_W+1:2], act[1], act[0],
               exp[RW-1 -: W], exp[SEL_W+1:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [RW-1:0] dut_vec();
    return {bus.out, bus.cur_ch, bus.out_valid, bus.update};
  endfunction

  // Monitor: one output sample per edge while expectations are queued.
  initial begin
    logic [RW-1:0] e;
    string t;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        compare(t, dut_vec(), e);
      end
    end
  end

  // Called at a falling edge: drive inputs for the next rising edge.
  task automatic apply(input logic [1:0] md, input logic [SEL_W-1:0] s,
                       input logic [N_CH-1:0] msk, input logic [DW-1:0] d, input string tag);
    bus.mode = md; bus.sel = s; bus.en_mask = msk; bus.inp = d;
    model_edge(md, int'(s), msk, d);
    exp_q.push_back(model_vec());
    tag_q.push_back(tag);
  endtask

  task automatic step(input logic [1:0] md, input logic [SEL_W-1:0] s,
                      input logic [N_CH-1:0] msk, input logic [DW-1:0] d, input string tag);
    @(negedge CLOCK_50);
    apply(md, s, msk, d, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLOCK_50);
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [DW-1:0]    d;
    logic [N_CH-1:0]  msk;
    logic [1:0]       md;
    logic [SEL_W-1:0] s;

    bus.inp = '0; bus.sel = '0; bus.mode = 2'b00; bus.en_mask = '0;
    model_reset();
    #12;
    compare("reset_initial", dut_vec(), model_vec());

    // Manual select
    d = 7'b1010010;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    apply(2'b00, 3'd1, 7'h7F, d, "manual_sel1");
    step(2'b00, 3'd1, 7'h7F, d, "manual_sel1_hold");
    step(2'b00, 3'd6, 7'h7F, d, "manual_sel6");
    step(2'b00, 3'd6, 7'h7F, d, "manual_sel6_hold");
    step(2'b00, 3'd7, 7'h7F, d, "manual_sel7_oob");
    step(2'b00, 3'd7, 7'h7F, d, "manual_sel7_oob_hold");
    step(2'b00, 3'd3, 7'h77, d, "manual_disabled");

    // Scan over channels 0,2,4
    step(2'b00, 3'd0, 7'b0010101, d, "scan_setup");
    for (int i = 0; i < 14; i++) step(2'b01, 3'd0, 7'b0010101, d, "scan_024");
    for (int i = 0; i < 3; i++)  step(2'b01, 3'd0, 7'b0000000, d, "scan_mask_zero");
    for (int i = 0; i < 8; i++)  step(2'b01, 3'd0, 7'b1000000, d, "scan_single");

    // Hold at cur_ch=2, count=1
    for (int i = 0; i < 40; i++) begin
      step(2'b01, 3'd0, 7'b0010101, d, "hold_approach");
      if (m_state == 1 && m_cur == 2 && m_cnt == 1) break;
    end
    for (int i = 0; i < 10; i++) begin
      d = ~d;
      step(2'b10, 3'd0, 7'b0010101, d, "hold_frozen");
    end
    for (int i = 0; i < 8; i++) step(2'b01, 3'd0, 7'b0010101, d, "hold_resume");

    // Mode change on the same edge as dwell expiry
    for (int i = 0; i < 40; i++) begin
      step(2'b01, 3'd5, 7'h7F, d, "expiry_approach");
      if (m_state == 1 && m_cnt == DWELL - 1) break;
    end
    step(2'b00, 3'd5, 7'h7F, d, "expiry_vs_manual");
    step(2'b00, 3'd5, 7'h7F, d, "expiry_manual_sel5");
    step(2'b01, 3'd5, 7'h7F, d, "expiry_rescan");

    // Randomised traffic
    md  = 2'b01;
    msk = 7'h7F;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       msk = N_CH'(1) << $urandom_range(0, N_CH - 1);
          1:       msk = '0;
          default: msk = N_CH'($urandom);
        endcase
      end
      s = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      d = DW'($urandom);
      step(md, s, msk, d, "random");
    end

    // Asynchronous reset in the middle of a scan dwell
    for (int i = 0; i < 6; i++) step(2'b01, 3'd0, 7'h7F, d, "prereset_scan");
    drain();
    @(posedge CLOCK_50);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    compare("reset_mid_scan", dut_vec(), model_vec());
    @(posedge CLOCK_50);
    #1;
    compare("reset_held", dut_vec(), model_vec());
    @(negedge CLOCK_50);
    resetn = 1'b1;
    apply(2'b01, 3'd4, 7'h7F, d, "post_reset_first");
    for (int i = 0; i < 10; i++) step(2'b01, 3'd4, 7'h7F, d, "post_reset_scan");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
